shumaguan_rx: RTL and testbench
===============================

Name: shumaguan_rx

Overview:
Receive-side monitor for the two-digit multiplexed 7-segment bus (discode/enable) produced by the washer display driver. It samples the scanned bus on qclock and reconstructs the tens and ones BCD digits once each pattern is stable. It pulses a frame strobe when both digits have been refreshed and flags illegal patterns and a stalled scan. It sits beside the display driver for self-check in the bench, and on-chip for display readback.

Parameters:
STABLE_CNT, 4, consecutive rising edges a sampled {enable,discode} must stay unchanged before it is committed (>=2)
TIMEOUT, 1000, cycles without any commit before stalled asserts
SEG_ACTIVE_LOW, 0, 1 = discode segments are lit when 0
EN_ACTIVE_LOW, 1, 1 = enable bits select a digit when 0

Ports:
qclock  in  1  system clock; all state changes on the rising edge
reset  in  1  asynchronous, active-high; clears all state immediately
discode  in  7  segment bus {g,f,e,d,c,b,a}, bit0 = a
enable  in  2  digit select; bit0 = ones digit, bit1 = tens digit
num1  out  4  committed tens digit (BCD)
num0  out  4  committed ones digit (BCD)
frame_valid  out  1  one-cycle pulse when num1/num0 are updated
err  out  1  one-cycle pulse on an illegal committed pattern
stalled  out  1  level; no commit seen for TIMEOUT cycles

Behaviour:
- Reset values: num1=0, num0=0, frame_valid=0, err=0, stalled=0. Sample register, stability counter, timeout counter, pending digits and FSM all clear; FSM=EMPTY.
- Sampling: {enable,discode} is registered every edge. First polarity-normalise per parameters, giving sel[1:0] and seg[6:0] as active-high.
- Stability counter:
  - Resets to 1 on any edge where the new sample differs from the held sample.
  - Otherwise increments, saturating at STABLE_CNT.
  - A commit fires on the edge where the counter reaches STABLE_CNT: exactly once per stable period.
  - With STABLE_CNT=4, a value first captured at edge 1 and held commits at edge 4.
- Segment decode (active-high gfedcba):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Any other pattern, including 00, is illegal.
- Commit handling:
  - sel=01: ones digit. sel=10: tens digit.
  - sel=00: blank phase. Ignored, no err, but the timeout counter is still reset.
  - sel=11: illegal.
  - On an illegal sel or segment pattern: err pulses for 1 cycle on the commit edge. Pending state is unchanged.
- Frame FSM (states EMPTY, HAVE_ONES, HAVE_TENS):
  - EMPTY: a legal ones commit stores pend0 and goes to HAVE_ONES. A legal tens commit stores pend1 and goes to HAVE_TENS.
  - HAVE_ONES: a ones commit overwrites pend0 and stays. A tens commit completes the frame.
  - HAVE_TENS: symmetric to HAVE_ONES.
  - Frame completion: on that same commit edge, num1/num0 are loaded with the pend values (the completing digit is taken directly from the decode), frame_valid=1 for that cycle, and the FSM returns to EMPTY.
  - A frame is produced even if the values are unchanged.
- Timeout:
  - The counter increments every cycle and clears on any commit, including blank commits.
  - stalled=1 when the counter reaches TIMEOUT. The counter saturates there.
  - stalled drops on the edge of the next commit.
- Illegal commits do not clear the timeout counter.
- Simultaneous events: err and frame_valid are mutually exclusive, since each commit is a single pattern.
- Reset mid-frame: pending digits are discarded. The first frame after reset needs both digits committed again.
- Widths: the stability counter is sized $clog2(STABLE_CNT+1). The timeout counter is sized $clog2(TIMEOUT+1).

Test Plan:
- Reset, then hold enable=2'b10 (EN_ACTIVE_LOW, ones selected) with discode=7'h4F for 4 edges, then enable=2'b01 with discode=7'h06 for 4 edges -> no pulse after the first digit; after the tens commit, frame_valid pulses once with num1=1, num0=3.
- Connect the display driver with code1/code2 stepping 13, 14, 23, 26, 52, 00 (each held 100 scan periods) -> frame_valid recurs, and num1/num0 track each value within two scan phases of the change; err never asserts.
- Present discode=7'h4F for only 3 edges (glitch), then a legal 5 for 4 edges on the ones digit -> the 3 is never committed; pend0=5.
- Commit discode=7'h77 (ones) -> err high for exactly 1 cycle, FSM state and num outputs unchanged. Repeat with both digits selected (enable=2'b00 active-low) and discode=7'h3F -> err pulse.
- Freeze the inputs after one commit -> stalled rises exactly 1000 cycles after that commit. Resume scanning -> stalled falls on the first commit edge.
- Assert reset while in HAVE_ONES with pend0=7, then commit only tens=2 -> no frame_valid; num1=0, num0=0 until a ones commit follows.

Source files
------------

// File: rtl/shumaguan_rx.sv
// shumaguan_rx: receive-side monitor for a two-digit multiplexed 7-segment bus.
// Debounces the scanned {enable,discode} bus, decodes the segments back to BCD,
// assembles tens/ones into frames and flags illegal patterns or a stalled scan.
module shumaguan_rx #(
    parameter int STABLE_CNT     = 4,
    parameter int TIMEOUT        = 1000,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit EN_ACTIVE_LOW  = 1'b1
) (
    input  logic       qclock,
    input  logic       reset,
    input  logic [6:0] discode,
    input  logic [1:0] enable,
    output logic [3:0] num1,
    output logic [3:0] num0,
    output logic       frame_valid,
    output logic       err,
    output logic       stalled
);
    localparam int SW = $clog2(STABLE_CNT + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CNT);
    localparam logic [TW-1:0] TOUT_MAX = TW'(TIMEOUT);
    // XOR mask that turns the raw bus into active-high select/segment bits
    localparam logic [8:0] POL_MASK = {{2{EN_ACTIVE_LOW}}, {7{SEG_ACTIVE_LOW}}};

    typedef enum logic [1:0] {EMPTY, HAVE_ONES, HAVE_TENS} state_t;

    logic [8:0]    raw_bus;
    logic [8:0]    norm_bus;
    logic [1:0]    sel;
    logic [6:0]    seg;
    logic          dec_ok;
    logic [3:0]    dec_digit;
    logic          commit;

    logic [8:0]    sample_q, sample_d;
    logic [SW-1:0] stab_q, stab_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [3:0]    pend0_q, pend0_d;
    logic [3:0]    pend1_q, pend1_d;
    logic [3:0]    num1_q, num1_d;
    logic [3:0]    num0_q, num0_d;
    logic          fv_q, fv_d;
    logic          err_q, err_d;
    logic          stalled_q, stalled_d;
    state_t        state_q, state_d;

    assign raw_bus = {enable, discode};

    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_pol
            assign norm_bus[gi] = raw_bus[gi] ^ POL_MASK[gi];
        end
    endgenerate

    assign sel = norm_bus[8:7];
    assign seg = norm_bus[6:0];

    // Decode an active-high gfedcba pattern; {valid, digit}
    function automatic logic [4:0] seg_decode(input logic [6:0] s);
        logic [4:0] r;
        r = 5'h00;
        case (s)
            7'h3F:   r = {1'b1, 4'd0};
            7'h06:   r = {1'b1, 4'd1};
            7'h5B:   r = {1'b1, 4'd2};
            7'h4F:   r = {1'b1, 4'd3};
            7'h66:   r = {1'b1, 4'd4};
            7'h6D:   r = {1'b1, 4'd5};
            7'h7D:   r = {1'b1, 4'd6};
            7'h07:   r = {1'b1, 4'd7};
            7'h7F:   r = {1'b1, 4'd8};
            7'h6F:   r = {1'b1, 4'd9};
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    assign {dec_ok, dec_digit} = seg_decode(seg);

    // Stability counter: restart on any change, saturate once the value has settled
    always_comb begin
        sample_d = raw_bus;
        if (raw_bus != sample_q) begin
            stab_d = SW'(1);
        end else if (stab_q == STAB_MAX) begin
            stab_d = stab_q;
        end else begin
            stab_d = stab_q + SW'(1);
        end
    end

    // A commit happens only on the edge the counter first reaches the threshold
    assign commit = (stab_d == STAB_MAX) && (stab_q != STAB_MAX);

    // Frame FSM, digit capture, error pulse and scan-timeout bookkeeping
    always_comb begin
        state_d = state_q;
        pend0_d = pend0_q;
        pend1_d = pend1_q;
        num1_d  = num1_q;
        num0_d  = num0_q;
        fv_d    = 1'b0;
        err_d   = 1'b0;
        tcnt_d  = (tcnt_q == TOUT_MAX) ? tcnt_q : tcnt_q + TW'(1);
        if (commit) begin
            if (sel == 2'b00) begin
                // blank phase still proves the scan is alive
                tcnt_d = '0;
            end else if (sel == 2'b11 || !dec_ok) begin
                err_d = 1'b1;
            end else begin
                tcnt_d = '0;
                if (sel == 2'b01) begin
                    if (state_q == HAVE_TENS) begin
                        num1_d  = pend1_q;
                        num0_d  = dec_digit;
                        fv_d    = 1'b1;
                        state_d = EMPTY;
                    end else begin
                        pend0_d = dec_digit;
                        state_d = HAVE_ONES;
                    end
                end else begin
                    if (state_q == HAVE_ONES) begin
                        num1_d  = dec_digit;
                        num0_d  = pend0_q;
                        fv_d    = 1'b1;
                        state_d = EMPTY;
                    end else begin
                        pend1_d = dec_digit;
                        state_d = HAVE_TENS;
                    end
                end
            end
        end
        stalled_d = (tcnt_d == TOUT_MAX);
    end

    // State registers with asynchronous clear
    always_ff @(posedge qclock or posedge reset) begin
        if (reset) begin
            sample_q  <= '0;
            stab_q    <= '0;
            tcnt_q    <= '0;
            pend0_q   <= '0;
            pend1_q   <= '0;
            num1_q    <= '0;
            num0_q    <= '0;
            fv_q      <= 1'b0;
            err_q     <= 1'b0;
            stalled_q <= 1'b0;
            state_q   <= EMPTY;
        end else begin
            sample_q  <= sample_d;
            stab_q    <= stab_d;
            tcnt_q    <= tcnt_d;
            pend0_q   <= pend0_d;
            pend1_q   <= pend1_d;
            num1_q    <= num1_d;
            num0_q    <= num0_d;
            fv_q      <= fv_d;
            err_q     <= err_d;
            stalled_q <= stalled_d;
            state_q   <= state_d;
        end
    end

    assign num1        = num1_q;
    assign num0        = num0_q;
    assign frame_valid = fv_q;
    assign err         = err_q;
    assign stalled     = stalled_q;

endmodule

// File: tb/tb_shumaguan_rx.sv
// Testbench for shumaguan_rx: spec vector table, hand-written corner sequences
// and a randomized scanning display, all checked against a history-based model.
module tb_shumaguan_rx;
    localparam int S    = 4;
    localparam int TOUT = 1000;
    localparam logic [6:0] SEG_TAB [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                            7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    logic       qclock = 1'b0;
    logic       reset  = 1'b0;
    logic [6:0] discode = '0;
    logic [1:0] enable  = '0;
    logic [3:0] num1, num0;
    logic       frame_valid, err, stalled;

    int n_checks = 0;
    int n_fail   = 0;

    shumaguan_rx #(
        .STABLE_CNT(S),
        .TIMEOUT(TOUT),
        .SEG_ACTIVE_LOW(1'b0),
        .EN_ACTIVE_LOW(1'b1)
    ) dut (
        .qclock(qclock),
        .reset(reset),
        .discode(discode),
        .enable(enable),
        .num1(num1),
        .num0(num0),
        .frame_valid(frame_valid),
        .err(err),
        .stalled(stalled)
    );

    always #5 qclock = ~qclock;

    // ---------------- reference model ----------------
    logic [8:0] hist [$];
    int         edge_no, last_clear;
    bit         have_ones, have_tens;
    logic [3:0] p0, p1;
    logic [3:0] m_num1, m_num0;
    logic       m_fv, m_err, m_stalled;

    function automatic int digit_of(input logic [6:0] s);
        for (int i = 0; i < 10; i++) if (SEG_TAB[i] == s) return i;
        return -1;
    endfunction

    task automatic model_reset();
        hist.delete();
        edge_no = 0; last_clear = 0;
        have_ones = 0; have_tens = 0;
        p0 = 0; p1 = 0; m_num1 = 0; m_num0 = 0;
        m_fv = 0; m_err = 0; m_stalled = 0;
    endtask

    // One rising edge seen by the model: commit = value held for exactly S edges
    task automatic model_step(input logic [8:0] raw);
        int n, d;
        bit same, cmt;
        logic [1:0] sel;
        m_fv = 0; m_err = 0;
        edge_no++;
        hist.push_back(raw);
        if (hist.size() > S + 1) void'(hist.pop_front());
        n = hist.size();
        cmt = 0;
        if (edge_no >= S) begin
            same = 1;
            for (int i = 1; i < S; i++) if (hist[n-1-i] != raw) same = 0;
            if (same) begin
                if (edge_no == S) cmt = 1;
                else if (hist[n-1-S] != raw) cmt = 1;
            end
        end
        if (cmt) begin
            sel = ~raw[8:7];
            d = digit_of(raw[6:0]);
            if (sel == 2'b00) begin
                last_clear = edge_no;
            end else if (sel == 2'b11 || d < 0) begin
                m_err = 1;
            end else begin
                last_clear = edge_no;
                if (sel == 2'b01) begin
                    if (have_tens) begin
                        m_num1 = p1; m_num0 = 4'(d); m_fv = 1; have_tens = 0;
                    end else begin
                        p0 = 4'(d); have_ones = 1;
                    end
                end else begin
                    if (have_ones) begin
                        m_num1 = 4'(d); m_num0 = p0; m_fv = 1; have_ones = 0;
                    end else begin
                        p1 = 4'(d); have_tens = 1;
                    end
                end
            end
        end
        m_stalled = (edge_no - last_clear) >= TOUT;
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cycle(input logic [1:0] en, input logic [6:0] dc);
        enable = en; discode = dc;
        @(posedge qclock);
        model_step({en, dc});
        #1;
        check($sformatf("model@%0d", edge_no), {21'd0, num1, num0, frame_valid, err, stalled},
              {21'd0, m_num1, m_num0, m_fv, m_err, m_stalled});
    endtask

    task automatic hold_pat(input logic [8:0] raw, input int n);
        for (int k = 0; k < n; k++) cycle(raw[8:7], raw[6:0]);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge qclock);
        #1;
        reset = 1'b0;
    endtask

    typedef struct {
        logic [1:0] en;
        logic [6:0] dc;
        int         hold;
        logic [3:0] n1;
        logic [3:0] n0;
        int         fvc;
        int         erc;
    } vec_t;

    vec_t vecs [11];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fvc, erc, stall_n, t, o;

        // enable is active-low: 2'b10 = ones, 2'b01 = tens, 2'b11 = blank, 2'b00 = both
        vecs[0]  = '{2'b10, 7'h4F, 4, 4'd0, 4'd0, 0, 0};  // ones 3 pending
        vecs[1]  = '{2'b01, 7'h06, 4, 4'd1, 4'd3, 1, 0};  // tens 1 -> frame 13
        vecs[2]  = '{2'b10, 7'h77, 4, 4'd1, 4'd3, 0, 1};  // illegal segments
        vecs[3]  = '{2'b00, 7'h3F, 4, 4'd1, 4'd3, 0, 1};  // both digits selected
        vecs[4]  = '{2'b11, 7'h00, 4, 4'd1, 4'd3, 0, 0};  // blank phase
        vecs[5]  = '{2'b10, 7'h6D, 4, 4'd1, 4'd3, 0, 0};  // ones 5 pending
        vecs[6]  = '{2'b10, 7'h7F, 4, 4'd1, 4'd3, 0, 0};  // ones overwritten by 8
        vecs[7]  = '{2'b01, 7'h5B, 4, 4'd2, 4'd8, 1, 0};  // tens 2 -> frame 28
        vecs[8]  = '{2'b01, 7'h7D, 4, 4'd2, 4'd8, 0, 0};  // tens 6 pending
        vecs[9]  = '{2'b10, 7'h4F, 3, 4'd2, 4'd8, 0, 0};  // 3-edge glitch, never committed
        vecs[10] = '{2'b10, 7'h07, 6, 4'd6, 4'd7, 1, 0};  // ones 7 -> frame 67

        do_reset();
        check("rst_num1", num1, 0);
        check("rst_num0", num0, 0);
        check("rst_fv", frame_valid, 0);
        check("rst_err", err, 0);
        check("rst_stalled", stalled, 0);

        // table-driven vectors
        for (int v = 0; v < 11; v++) begin
            fvc = 0; erc = 0;
            for (int k = 0; k < vecs[v].hold; k++) begin
                cycle(vecs[v].en, vecs[v].dc);
                fvc += int'(frame_valid);
                erc += int'(err);
            end
            check($sformatf("vec%0d_nums", v), {num1, num0}, {vecs[v].n1, vecs[v].n0});
            check($sformatf("vec%0d_fv_pulses", v), fvc, vecs[v].fvc);
            check($sformatf("vec%0d_err_pulses", v), erc, vecs[v].erc);
        end

        // stall: freeze after a tens commit, stalled rises exactly TOUT edges later
        hold_pat({2'b01, 7'h6F}, S);
        stall_n = 0;
        while (stalled !== 1'b1 && stall_n <= TOUT + 100) begin
            cycle(2'b01, 7'h6F);
            stall_n++;
        end
        check("stall_rise_edges", stall_n, TOUT);
        hold_pat({2'b10, 7'h66}, S - 1);
        check("stall_hold", stalled, 1);
        cycle(2'b10, 7'h66);
        check("stall_fall", stalled, 0);
        check("stall_frame", {num1, num0, frame_valid}, {4'd9, 4'd4, 1'b1});

        // reset while holding a pending ones digit
        hold_pat({2'b10, 7'h07}, S);
        reset = 1'b1;
        #1;
        check("async_rst_outputs", {num1, num0, frame_valid, err, stalled}, 11'd0);
        model_reset();
        repeat (2) @(posedge qclock);
        #1;
        reset = 1'b0;
        fvc = 0;
        for (int k = 0; k < S; k++) begin
            cycle(2'b01, 7'h5B);
            fvc += int'(frame_valid);
        end
        check("post_rst_no_frame", fvc, 0);
        check("post_rst_nums", {num1, num0}, 8'h00);
        hold_pat({2'b10, 7'h66}, S);
        check("post_rst_frame", {num1, num0, frame_valid}, {4'd2, 4'd4, 1'b1});

        // randomized scanning display with glitches and illegal phases
        for (int v = 0; v < 40; v++) begin
            t = $urandom_range(9);
            o = $urandom_range(9);
            for (int sc = 0; sc < 3; sc++) begin
                if ($urandom_range(7) == 0) hold_pat(9'($urandom), $urandom_range(1, 5));
                hold_pat({2'b10, SEG_TAB[o]}, $urandom_range(3, 8));
                hold_pat({2'b11, 7'($urandom)}, $urandom_range(1, 3));
                hold_pat({2'b01, SEG_TAB[t]}, $urandom_range(3, 8));
                hold_pat({2'b11, 7'($urandom)}, $urandom_range(1, 3));
            end
            if (v == 20) do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
